// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: steps START, DATA, optional PARITY and STOP
// slots at one state per bit-rate clock and drives the TX datapath controls.
module uart_tx_ctrl #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  output logic             data_accept,
  output logic             ser_en,
  output logic [1:0]       mux_sel,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BUS_WIDTH - 1);

  localparam logic [1:0] MUX_IDLE   = 2'b00;
  localparam logic [1:0] MUX_START  = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_par_en;
  logic             w_accept;
  logic             w_last_bit;

  // A new byte is taken only between frames or in the final stop slot.
  assign w_accept   = Data_Valid & ((r_state == ST_IDLE) | (r_state == ST_STOP)) & ~RST;
  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_par_en  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_par_en <= PAR_EN;
      end
      if ((r_state == ST_DATA) && !w_last_bit) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end else begin
        r_bit_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next  = ST_IDLE;
    ser_en  = 1'b0;
    mux_sel = MUX_IDLE;
    busy    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = w_accept ? ST_START : ST_IDLE;
      end
      ST_START: begin
        busy    = 1'b1;
        mux_sel = MUX_START;
        w_next  = ST_DATA;
      end
      ST_DATA: begin
        busy    = 1'b1;
        mux_sel = MUX_DATA;
        ser_en  = 1'b1;
        if (w_last_bit) begin
          w_next = r_par_en ? ST_PARITY : ST_STOP;
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        busy    = 1'b1;
        mux_sel = MUX_PARITY;
        w_next  = ST_STOP;
      end
      ST_STOP: begin
        busy   = 1'b1;
        w_next = w_accept ? ST_START : ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign data_accept = w_accept;
  assign bit_cnt     = r_bit_cnt;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: an 8-bit instance for the main frame
// scenarios and a 5-bit instance for the narrow-width parity frame.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv_a, pe_a, acc_a, ser_a, busy_a;
  logic [1:0] mux_a;
  logic [3:0] cnt_a;
  logic       dv_b, pe_b, acc_b, ser_b, busy_b;
  logic [1:0] mux_b;
  logic [2:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.BUS_WIDTH(8), .CNT_W(4)) u_dut_a (
    .CLK(clk), .RST(rst), .Data_Valid(dv_a), .PAR_EN(pe_a),
    .data_accept(acc_a), .ser_en(ser_a), .mux_sel(mux_a),
    .busy(busy_a), .bit_cnt(cnt_a)
  );

  uart_tx_ctrl #(.BUS_WIDTH(5), .CNT_W(3)) u_dut_b (
    .CLK(clk), .RST(rst), .Data_Valid(dv_b), .PAR_EN(pe_b),
    .data_accept(acc_b), .ser_en(ser_b), .mux_sel(mux_b),
    .busy(busy_b), .bit_cnt(cnt_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count slots of the 8-bit instance from the current cycle until busy drops.
  task automatic measure_a(output int n_busy, output int n_ser, output int n_par);
    n_busy = 0; n_ser = 0; n_par = 0;
    while (busy_a && n_busy < 40) begin
      n_busy++;
      if (ser_a) n_ser++;
      if (mux_a == 2'b11) n_par++;
      tick();
    end
  endtask

  task automatic measure_b(output int n_busy, output int n_ser, output int n_par);
    n_busy = 0; n_ser = 0; n_par = 0;
    while (busy_b && n_busy < 40) begin
      n_busy++;
      if (ser_b) n_ser++;
      if (mux_b == 2'b11) n_par++;
      tick();
    end
  endtask

  initial begin
    int nb, ns, np;
    int acc_cnt, first_acc, second_acc, third_acc, idle_gaps;

    rst = 1'b1; dv_a = 1'b1; pe_a = 1'b0; dv_b = 1'b0; pe_b = 1'b0;
    #1;
    check("accept_during_reset", int'(acc_a), 0);
    tick();
    check("reset_busy", int'(busy_a), 0);
    check("reset_mux", int'(mux_a), 0);
    check("reset_cnt", int'(cnt_a), 0);
    check("reset_ser", int'(ser_a), 0);
    rst = 1'b0; dv_a = 1'b0;
    tick();

    // Single frame without parity, cycle by cycle.
    dv_a = 1'b1; pe_a = 1'b0;
    #1;
    check("single_accept", int'(acc_a), 1);
    tick();
    dv_a = 1'b0;
    check("single_start_mux", int'(mux_a), 1);
    check("single_start_busy", int'(busy_a), 1);
    check("single_start_ser", int'(ser_a), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("single_data_mux", int'(mux_a), 2);
      check("single_data_ser", int'(ser_a), 1);
      check("single_data_cnt", int'(cnt_a), i);
    end
    tick();
    check("single_stop_mux", int'(mux_a), 0);
    check("single_stop_busy", int'(busy_a), 1);
    check("single_stop_cnt", int'(cnt_a), 0);
    tick();
    check("single_idle_busy", int'(busy_a), 0);

    // Parity frame; PAR_EN dropped after the accept must not remove the slot.
    dv_a = 1'b1; pe_a = 1'b1;
    #1;
    check("par_accept", int'(acc_a), 1);
    tick();
    dv_a = 1'b0;
    check("par_start_mux", int'(mux_a), 1);
    tick();
    pe_a = 1'b0;
    measure_a(nb, ns, np);
    check("par_busy_after_start", nb, 10);
    check("par_ser_cycles", ns, 8);
    check("par_parity_slots", np, 1);
    tick();

    // Back-to-back frames with Data_Valid held high.
    dv_a = 1'b1; pe_a = 1'b0;
    acc_cnt = 0; first_acc = -1; second_acc = -1; third_acc = -1; idle_gaps = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (acc_a) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = c;
        else if (second_acc < 0) second_acc = c;
        else if (third_acc < 0) third_acc = c;
      end
      if (c > 0 && !busy_a) idle_gaps++;
      tick();
    end
    dv_a = 1'b0;
    check("b2b_accepts", acc_cnt, 3);
    check("b2b_first_at", first_acc, 0);
    check("b2b_gap1", second_acc - first_acc, 10);
    check("b2b_gap2", third_acc - second_acc, 10);
    check("b2b_no_idle", idle_gaps, 0);
    measure_a(nb, ns, np);
    check("b2b_drain_idle", int'(busy_a), 0);
    tick();

    // Request inside DATA is ignored and does not disturb the frame.
    dv_a = 1'b1;
    #1;
    check("ign_accept_idle", int'(acc_a), 1);
    tick();
    dv_a = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("ign_cnt_at_pulse", int'(cnt_a), 3);
    dv_a = 1'b1;
    #1;
    check("ign_no_accept_data", int'(acc_a), 0);
    tick();
    dv_a = 1'b0;
    check("ign_cnt_continues", int'(cnt_a), 4);
    measure_a(nb, ns, np);
    check("ign_remaining_busy", nb, 5);
    check("ign_idle_after", int'(mux_a), 0);
    tick();

    // Reset in the middle of DATA, with Data_Valid held.
    dv_a = 1'b1;
    #1;
    tick();
    dv_a = 1'b0;
    tick(); tick(); tick();
    check("rst_pre_cnt", int'(cnt_a), 2);
    rst = 1'b1; dv_a = 1'b1;
    tick();
    check("rst_busy", int'(busy_a), 0);
    check("rst_mux", int'(mux_a), 0);
    check("rst_cnt", int'(cnt_a), 0);
    check("rst_ser", int'(ser_a), 0);
    check("rst_idle_no_accept", int'(acc_a), 0);
    tick();
    check("rst_hold_busy", int'(busy_a), 0);
    rst = 1'b0; dv_a = 1'b0;
    tick();

    // Narrow 5-bit instance with parity.
    dv_b = 1'b1; pe_b = 1'b1;
    #1;
    check("w5_accept", int'(acc_b), 1);
    tick();
    dv_b = 1'b0; pe_b = 1'b0;
    check("w5_start_mux", int'(mux_b), 1);
    measure_b(nb, ns, np);
    check("w5_frame_len", nb, 8);
    check("w5_ser_cycles", ns, 5);
    check("w5_parity_slots", np, 1);
    check("w5_idle", int'(busy_b), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
